// File: rtl/timer_pkg.sv
// Shared types and default sizes for the loadable down-counter timer.
package timer_pkg;

  localparam int DEF_WIDTH  = 7;
  localparam int DEF_PCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } timer_state_t;

endpackage : timer_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts a sampled value to zero, pulses done,
// optionally reloads, and keeps a saturating count of completed periods.
// Supports level pause (hold) and level abort (return to idle).
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              auto_reload,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  timer_state_t      state, state_d;
  logic [WIDTH-1:0]  count_d;
  logic              busy_d;
  logic              done_d;
  logic [PCNT_W-1:0] periods_d;
  logic [WIDTH-1:0]  reload_q, reload_d;
  logic              arm_q, arm_d;
  // Set once the zero of the current period has produced its done pulse, so
  // the following edge reloads or retires instead of pulsing again. It is
  // held across a pause so a pause landing just after done cannot re-pulse.
  logic              pulsed_q, pulsed_d;

  logic [PCNT_W-1:0] periods_inc;

  // Saturating increment of the completed-period counter.
  always_comb begin
    periods_inc = (periods == {PCNT_W{1'b1}}) ? periods : periods + PCNT_W'(1);
  end

  // Next-state and datapath: abort > start (IDLE only) > pause > decrement.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    state_d   = state;
    count_d   = count;
    busy_d    = busy;
    done_d    = 1'b0;
    periods_d = periods;
    reload_d  = reload_q;
    arm_d     = arm_q;
    pulsed_d  = pulsed_q;

    if (abort) begin
      state_d  = IDLE;
      count_d  = '0;
      busy_d   = 1'b0;
      pulsed_d = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            reload_d  = load_val;
            arm_d     = auto_reload;
            periods_d = '0;
            count_d   = load_val;
            state_d   = RUN;
            busy_d    = 1'b1;
            pulsed_d  = 1'b0;
          end
        end

        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (count > WIDTH'(1)) begin
            count_d = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            count_d   = '0;
            done_d    = 1'b1;
            pulsed_d  = 1'b1;
            periods_d = periods_inc;
          end else if (!pulsed_q) begin
            // Zero reached without passing through one (load or reload of 0).
            done_d    = 1'b1;
            pulsed_d  = 1'b1;
            periods_d = periods_inc;
          end else if (arm_q) begin
            count_d  = reload_q;
            pulsed_d = 1'b0;
          end else begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            pulsed_d = 1'b0;
          end
        end

        PAUSE: begin
          // Resume costs one edge; decrementing restarts on the next one.
          if (!pause) state_d = RUN;
        end

        default: begin
          state_d = IDLE;
          count_d = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // update together from values computed before the edge.
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      periods  <= '0;
      reload_q <= '0;
      arm_q    <= 1'b0;
      pulsed_q <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      busy     <= busy_d;
      done     <= done_d;
      periods  <= periods_d;
      reload_q <= reload_d;
      arm_q    <= arm_d;
      pulsed_q <= pulsed_d;
    end
  end

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer. A second instance with a 2-bit
// period counter shares the stimulus to exercise saturation. Expected values
// come from a period/position model of the countdown.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] load_val = '0;
  logic       auto_reload = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  logic [6:0] count, count_s;
  logic       busy, busy_s, done, done_s;
  logic [7:0] periods;
  logic [1:0] periods_s;

  int checks = 0;
  int errors = 0;

  down_counter_timer #(.WIDTH(7), .PCNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .count(count), .busy(busy), .done(done), .periods(periods)
  );

  down_counter_timer #(.WIDTH(7), .PCNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .count(count_s), .busy(busy_s), .done(done_s), .periods(periods_s)
  );

  always #5 clk = ~clk;

  // Reference model: a period of load value N occupies L positions
  // (L = N+1, or 2 when N = 0); position p shows max(N-p, 0) and done is
  // raised when an advance lands on the last position.
  bit m_active, m_paused, m_arm, m_done;
  int m_n, m_pos, m_per, m_per_sat;

  function automatic int plen(input int n);
    return (n == 0) ? 2 : n + 1;
  endfunction

  function automatic int m_count();
    if (!m_active) return 0;
    return (m_n > m_pos) ? m_n - m_pos : 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_paused = 0; m_arm = 0; m_done = 0;
    m_n = 0; m_pos = 0; m_per = 0; m_per_sat = 0;
  endtask

  task automatic model_edge();
    if (abort) begin
      m_active = 0; m_paused = 0; m_done = 0;
    end else if (!m_active) begin
      m_done = 0;
      if (start) begin
        m_n = load_val; m_arm = auto_reload; m_pos = 0;
        m_active = 1; m_paused = 0; m_per = 0; m_per_sat = 0;
      end
    end else if (m_paused) begin
      m_done = 0;
      if (!pause) m_paused = 0;
    end else if (pause) begin
      m_paused = 1; m_done = 0;
    end else if (m_pos == plen(m_n) - 1) begin
      m_done = 0;
      if (m_arm) m_pos = 0;
      else m_active = 0;
    end else begin
      m_pos++;
      m_done = (m_pos == plen(m_n) - 1);
      if (m_done) begin
        if (m_per < 255) m_per++;
        if (m_per_sat < 3) m_per_sat++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(m_count()));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("periods", 32'(periods), 32'(m_per));
    check("periods_sat", 32'(periods_s), 32'(m_per_sat));
    check("done_sat", 32'(done_s), 32'(m_done));
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, compare shortly after it.
  task automatic step(input logic s, input logic [6:0] lv, input logic ar,
                      input logic p, input logic ab);
    @(negedge clk);
    start = s; load_val = lv; auto_reload = ar; pause = p; abort = ab;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();

    // Reset state while rst is held low.
    #12;
    check("reset_count", 32'(count), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_periods", 32'(periods), 0);
    @(negedge clk);
    rst = 1'b1;

    // One-shot, load 5.
    step(1, 5, 0, 0, 0);
    check("oneshot_load", 32'(count), 5);
    check("oneshot_busy", 32'(busy), 1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 0);
      check("oneshot_done_only_last", 32'(done), (i == 5) ? 1 : 0);
    end
    check("oneshot_zero", 32'(count), 0);
    check("oneshot_periods", 32'(periods), 1);
    step(0, 0, 0, 0, 0);
    check("oneshot_idle", 32'(busy), 0);

    // Auto-reload, load 3: done every fourth edge.
    step(1, 3, 1, 0, 0);
    for (int i = 1; i <= 11; i++) step(0, 0, 0, 0, 0);
    check("reload_done3", 32'(done), 1);
    check("reload_periods3", 32'(periods), 3);
    step(0, 0, 0, 0, 0);
    check("reload_count", 32'(count), 3);
    step(0, 0, 0, 0, 1);

    // Pause at 10, then abort at 7.
    step(1, 20, 0, 0, 0);
    idle_steps(10);
    check("pause_pre", 32'(count), 10);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      check("pause_hold", 32'(count), 10);
    end
    step(0, 0, 0, 0, 0);
    check("pause_resume_edge", 32'(count), 10);
    step(0, 0, 0, 0, 0);
    check("pause_resumed", 32'(count), 9);
    idle_steps(2);
    check("abort_pre", 32'(count), 7);
    step(0, 0, 0, 0, 1);
    check("abort_count", 32'(count), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_periods", 32'(periods), 0);

    // Load 0: done one edge after busy rises, then idle.
    step(1, 0, 0, 0, 0);
    check("zero_busy", 32'(busy), 1);
    check("zero_nodone", 32'(done), 0);
    step(0, 0, 0, 0, 0);
    check("zero_done", 32'(done), 1);
    step(0, 0, 0, 0, 0);
    check("zero_idle", 32'(busy), 0);

    // Load 127 with an ignored start mid-count.
    step(1, 127, 0, 0, 0);
    for (int i = 1; i <= 127; i++) step(i == 50, 9, 1, 0, 0);
    check("max_done", 32'(done), 1);
    step(0, 0, 0, 0, 0);
    check("max_idle", 32'(busy), 0);

    // Pause arriving on the count==1 edge.
    step(1, 3, 0, 0, 0);
    idle_steps(1);
    check("p1_pre", 32'(count), 2);
    step(0, 0, 0, 0, 0);
    check("p1_one", 32'(count), 1);
    step(0, 0, 0, 1, 0);
    check("p1_held", 32'(count), 1);
    check("p1_nodone", 32'(done), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("p1_resume_nodone", 32'(done), 0);
    step(0, 0, 0, 0, 0);
    check("p1_done", 32'(done), 1);
    idle_steps(1);

    // Saturation: load 1 with reload gives 13 pulses in 25 edges.
    step(1, 1, 1, 0, 0);
    idle_steps(25);
    check("sat_periods", 32'(periods_s), 3);
    check("sat_main_periods", 32'(periods), 13);
    step(0, 0, 0, 0, 1);

    // Asynchronous reset mid-count at 40.
    step(1, 60, 0, 0, 0);
    idle_steps(20);
    check("rst_pre", 32'(count), 40);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_async_count", 32'(count), 0);
    check("rst_async_busy", 32'(busy), 0);
    check("rst_async_done", 32'(done), 0);
    check("rst_async_periods", 32'(periods), 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_hold_count", 32'(count), 0);
    rst = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic s, ar, p, ab;
      logic [6:0] lv;
      s  = ($urandom_range(0, 3) == 0);
      ar = $urandom_range(0, 1);
      p  = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 40) == 0);
      lv = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                       : 7'($urandom_range(0, 6));
      step(s, lv, ar, p, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_down_counter_timer
